// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle engine for the RV32M multiply/divide ops.
//
// An iterative shift-add multiplier and a restoring divider each retire one
// bit per cycle on operand magnitudes. The sign is fixed up on the final step.
// Divide-by-zero and signed overflow are resolved without iterating.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while idle
//   funct3  op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a    rs1 value (multiplicand / dividend)
//   op_b    rs2 value (multiplier / divisor)
//   flush   aborts the in-flight op; beats start and completion
//   busy    high whenever the sequencer is not idle
//   done    one-cycle pulse; result is valid in that cycle
//   result  final value, held until overwritten by a later op
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] AllOnes = '1;
    localparam logic [WIDTH-1:0] SignMin = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2:0]         fn_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;

    // Operand decode for the request presented on the inputs.
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             res_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_val;

    always_comb begin
        is_div   = funct3[2];
        // MUL/MULH: both signed; MULHSU: rs1 only; MULHU: none.
        // DIV/REM (funct3[0]=0): both signed; DIVU/REMU: none.
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & op_a[WIDTH-1];
        b_neg    = b_signed & op_b[WIDTH-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        // The remainder follows the dividend; everything else is the sign product.
        res_neg  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == SignMin) && (op_b == AllOnes);
        if (div_zero) begin
            special_val = funct3[1] ? op_a : AllOnes;
        end else begin
            special_val = funct3[1] ? '0 : SignMin;
        end
    end

    // One iteration of each datapath; both run, the op code picks the answer.
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   final_val;

    always_comb begin
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvsr_q};
        // A borrow out of the top bit means the divisor did not fit: restore.
        rem_d    = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        prod_fix = neg_q ? -acc_d : acc_d;
        quo_fix  = neg_q ? -quo_d : quo_d;
        rem_fix  = neg_q ? -rem_d : rem_d;
        case (fn_q)
            3'b000:                 final_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fn_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        fn_q     <= funct3;
                        neg_q    <= res_neg;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        rem_q    <= '0;
                        quo_q    <= a_mag;
                        dvsr_q   <= b_mag;
                        busy     <= 1'b1;
                        if (div_zero || div_ovf) begin
                            result  <= special_val;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q    <= acc_d;
                    mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    rem_q    <= rem_d;
                    quo_q    <= quo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // The final value is registered on entry to DONE so it
                    // lines up with the done pulse.
                    if (cnt_q == CntLast) begin
                        result  <= final_val;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: each issued op pushes its expected
// result and done edge; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    localparam logic [2:0] FMul    = 3'b000;
    localparam logic [2:0] FMulh   = 3'b001;
    localparam logic [2:0] FMulhsu = 3'b010;
    localparam logic [2:0] FMulhu  = 3'b011;
    localparam logic [2:0] FDiv    = 3'b100;
    localparam logic [2:0] FDivu   = 3'b101;
    localparam logic [2:0] FRem    = 3'b110;
    localparam logic [2:0] FRemu   = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   funct3 = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    logic [W-1:0] q_res[$];
    int           q_cyc[$];
    string        q_name[$];
    logic [W-1:0] last_res = '0;

    typedef struct packed {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         sp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV] = '{
        '{FMul,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
        '{FMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
        '{FMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{FMulhsu, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{FMulhsu, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
        '{FMul,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
        '{FMulh,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{FDiv,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
        '{FRem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{FDiv,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0},
        '{FRem,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
        '{FDivu,   32'd100,       32'd7,         32'd14,        1'b0},
        '{FRemu,   32'd100,       32'd7,         32'd2,         1'b0},
        '{FDivu,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{FDiv,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
        '{FRemu,   32'd5,         32'd0,         32'd5,         1'b1},
        '{FRem,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b1},
        '{FDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
        '{FRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1}
    };

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        string nm;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q_res.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with result %h, required no done",
                             result);
                end else begin
                    nm = q_name.pop_front();
                    check({nm, " result"}, result, q_res.pop_front());
                    check({nm, " done_edge"}, 32'(ecount), 32'(q_cyc.pop_front()));
                end
            end
        end
    endtask

    // Caller is at a negedge; returns shortly after the sampling edge.
    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit sp, input bit expect_done,
                         input string name);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            q_res.push_back(exp);
            q_cyc.push_back(ecount + (sp ? 0 : int'(W)));
            q_name.push_back(name);
            last_res = exp;
        end
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle_within_bound"}, 32'(busy), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state.
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, issued back-to-back as soon as the block is idle.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].sp, 1'b1,
                  $sformatf("vec%0d_f%0d", i, vecs[i].f));
            wait_idle($sformatf("vec%0d", i));
        end

        // Start pulsed mid-op is ignored: only one done may arrive.
        issue(FDivu, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "busy_start");
        repeat (4) @(negedge clk);
        start  = 1'b1;
        funct3 = FMul;
        op_a   = 32'd3;
        op_b   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");

        // Flush mid-divide: no done, result kept, immediate restart works.
        issue(FDiv, 32'd1000, 32'd9, 32'd0, 1'b0, 1'b0, "flushed_div");
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush result_held", result, last_res);
        issue(FDiv, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1, "after_flush");
        wait_idle("after_flush");

        // Flush on the same edge as a special-case start: nothing accepted.
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = FDiv;
        op_a   = 32'd5;
        op_b   = 32'd0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start busy", 32'(busy), 32'd0);
        check("flush_start result_held", result, last_res);
        @(negedge clk);

        // Asynchronous reset mid-multiply.
        issue(FMul, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, "reset_mul");
        repeat (18) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset result", result, last_res);

        issue(FMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1, "post_reset_mul");
        wait_idle("post_reset_mul");

        repeat (3) @(negedge clk);
        check("pending_expectations", 32'(q_res.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations. The single-cycle ALU path does not implement these. The execute stage issues an M-extension op (funct7 = 0000001) to this block and stalls on `busy` until `done`. Internally it runs an iterative shift-add multiplier and a restoring divider, one bit per cycle, with sign fix-up and RISC-V special-case handling.

## Interface
- `WIDTH`, 32: operand and result width; also the iteration count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  WIDTH  rs1 value (multiplicand or dividend).
- `op_b`  in  WIDTH  rs2 value (multiplier or divisor).
- `flush`  in  1  pipeline kill; aborts the in-flight op.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  final value; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 and `flush`=0: latch `funct3`, `op_a`, `op_b`.
  - Convert signed operands to magnitudes and record the result sign:
    - MUL/MULH: both operands signed.
    - MULHSU: only `op_a` signed.
    - DIV/REM: both signed; REM takes the dividend's sign.
    - MULHU, DIVU, REMU: unsigned, no conversion.
  - Clear the iteration counter (clog2(WIDTH) bits).
  - Go to CALC, except for the special cases below, which load `result` directly and go to DONE.
- **Special cases** (resolved in IDLE):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give `op_a`.
  - Signed overflow, DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- **CALC**: one iteration per cycle for exactly WIDTH cycles; counter runs 0..WIDTH-1.
  - Multiply: 2·WIDTH accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: shift the remainder left by 1, subtract the divisor, restore if negative, shift the quotient bit in.
  - Counter = WIDTH-1: go to DONE.
- **DONE**
  - Apply sign fix-up (two's-complement negate if the sign flag is set).
  - Write `result`:
    - MUL: low WIDTH bits.
    - MULH/MULHSU/MULHU: high WIDTH bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Assert `done` for this cycle only, then return to IDLE.
- **flush**: any state, including the cycle `start` is presented, forces IDLE on the next edge.
  - No `done` pulse.
  - `result` is unchanged.
  - `flush` takes priority over `start` and over the DONE transition.
- `start` while `busy`=1 is ignored; no queuing.
- Undefined `funct3` cannot occur (3 bits, all 8 codes used).

## Timing
- Reset (async, `rst_n`=0): state IDLE, `busy`=0, `done`=0, `result`=0, counter=0, internal registers 0. Reset mid-operation discards the op; no `done`.
- Normal op with `start` sampled at edge k:
  - `busy`=1 from after edge k.
  - CALC occupies cycles k+1 .. k+WIDTH.
  - DONE occupies cycle k+WIDTH+1; `done`=1 there (33 cycles after start for WIDTH=32).
  - `busy`=0 from edge k+WIDTH+2.
- Special case: DONE in cycle k+1; `done`=1 one cycle after start.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
- Outputs are registered; no combinational path from inputs to `busy`, `done` or `result`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start at cycle 0 → `done` at cycle 33, `result`=0xFFFFFFEB; `busy` high cycles 1–33.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- Special cases, each with `done` one cycle after start:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11; no `done`; `result` keeps its previous value. A new start at cycle 11 completes normally.
- `start` pulsed at cycle 5 during an op → ignored; only one `done`.
- `rst_n` low at cycle 20 of a MUL → `busy`/`done`/`result` = 0 immediately, no `done` after release.
